fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch stage for the RV32I core. Generalises the fixed PC/PC+4/instruction-ROM path into one block: a configurable-depth, loadable instruction memory with synchronous read, a PC sequencer with redirect for branches and jumps, and a registered valid/ready output towards decode. The block halts on out-of-range or misaligned fetch addresses and reports a fault instead of returning silent zeros. It sits between the core top and the decoder/register-file stage.

## Interface
Parameters:
- XLEN, 32, PC width in bits (≥ 32).
- DEPTH, 32, instruction memory words; power of two, ≥ 2. AW = $clog2(DEPTH).
- RESET_PC, 0, fetch address after reset; must be word-aligned.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_we  in  1  write one word into instruction memory.
- imem_waddr  in  AW  word index for the write.
- imem_wdata  in  32  instruction word to write.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  XLEN  new fetch byte address.
- out_valid  out  1  output stage holds an instruction or a fault.
- out_ready  in  1  consumer accepts the output this cycle.
- out_pc  out  XLEN  byte address of the output instruction.
- out_instr  out  32  fetched instruction word.
- out_fault  out  1  fetch address was misaligned or out of range.

## Operation
- State: fetch_pc (XLEN), FSM {RUN, HALT}, output register {out_valid, out_pc, out_instr, out_fault}, memory array DEPTH×32.
- Memory is not reset. It initialises to all-zero at elaboration. Writes are synchronous on imem_we.
- Fetch address check: fault = (fetch_pc[1:0] != 0) or (fetch_pc ≥ DEPTH*4). Index = fetch_pc[AW+1:2].
- Advance condition: state == RUN and (out_valid == 0 or out_ready == 1). When it holds, the output register loads:
  - out_pc = fetch_pc;
  - out_instr = mem[index], or 32'h00000013 (NOP) if faulting;
  - out_fault = fault;
  - out_valid = 1.
- On an advance without fault, fetch_pc ← fetch_pc + 4 (modulo 2^XLEN) and the FSM stays in RUN.
- On an advance with fault, fetch_pc is held and the FSM goes to HALT. No further advances occur until a redirect.
- If the output is consumed (out_ready == 1) and there is no advance, out_valid ← 0.
- If out_valid == 1 and out_ready == 0, all output fields hold stable.
- Redirect has priority over everything except reset. When redirect_valid == 1:
  - out_valid ← 0;
  - fetch_pc ← redirect_pc;
  - FSM ← RUN;
  - the current output is discarded whether or not out_ready is high.
- Same-cycle write and fetch to the same index: the fetch returns the old word (read-before-write).

## Timing
- Reset (async, any time, including mid-stall or mid-redirect): out_valid=0, out_pc=0, out_instr=0, out_fault=0, fetch_pc=RESET_PC, FSM=RUN. Memory contents are unchanged.
- After reset deasserts, the first rising edge produces out_valid=1, out_pc=RESET_PC.
- Latency is one cycle from fetch_pc to the output register.
- Sustained throughput is one instruction per cycle while out_ready=1.
- Redirect sampled at edge N: out_valid=0 after edge N, and the target instruction is valid after edge N+1. The redirect bubble is exactly one cycle.
- A memory write at edge N is visible to a fetch at edge N+1 or later.
- In HALT, out_valid stays 1 with the fault entry until it is consumed, then stays 0 until a redirect.

## Test plan
- Sequential fetch: DEPTH=32, write mem[0..3]=0x005303B3, 0x00000013, 0x00100093, 0x00208113; release reset with out_ready=1 → out_pc 0,4,8,12 on consecutive cycles with matching out_instr, out_fault=0.
- Backpressure: hold out_ready=0 for 3 cycles after the first valid → out_pc=0, out_instr=0x005303B3 stable. Raise out_ready → next cycle out_pc=4, with no skipped or duplicated PC.
- Redirect: redirect_valid with redirect_pc=0x10 while out_pc=4 is valid → next cycle out_valid=0, following cycle out_pc=0x10 with instr=mem[4].
- Range fault: redirect to 0x7C → out_pc=0x7C (fault=0), then out_pc=0x80 with out_fault=1 and out_instr=0x00000013. After it is consumed, out_valid stays 0 for ≥5 cycles. Redirect to 0 resumes fetch.
- Misaligned redirect to 0x6 → out_pc=0x6, out_fault=1, FSM in HALT.
- Async reset mid-stream with out_valid=1 and out_ready=0 → outputs clear immediately, without waiting for a clock edge. Memory contents are retained: after release, out_instr at PC 0 is still 0x005303B3.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch with loadable imem, redirect and fault halt
//   clk, reset (async, active-high)
//   imem_we/imem_waddr/imem_wdata : synchronous instruction memory write port
//   redirect_valid/redirect_pc    : flush output and restart fetch at redirect_pc
//   out_valid/out_ready           : registered handshake towards decode
//   out_pc/out_instr/out_fault    : fetched instruction, its address, fault flag
module fetch_unit #(
    parameter int XLEN = 32,
    parameter int DEPTH = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            imem_we,
    input  logic [$clog2(DEPTH)-1:0] imem_waddr,
    input  logic [31:0]     imem_wdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic            out_fault
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {RUN, HALT} state_t;

    state_t state, state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [31:0] mem [DEPTH] = '{default: '0};
    logic [AW-1:0] idx;
    logic fault, advance;

    assign idx = fetch_pc[AW+1:2];
    // any bit at or above DEPTH*4 means out of range (DEPTH is a power of two)
    assign fault = (|fetch_pc[1:0]) || (|fetch_pc[XLEN-1:AW+2]);

    always_comb begin
        advance = (state == RUN) && (!out_valid || out_ready);
        state_nxt = redirect_valid ? RUN : (advance && fault) ? HALT : state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else state <= state_nxt;
    end

    // the fetch below samples mem before this write lands: read-before-write
    always_ff @(posedge clk) begin
        if (imem_we) mem[imem_waddr] <= imem_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            out_valid <= 1'b0;
            out_pc <= '0;
            out_instr <= '0;
            out_fault <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            out_valid <= 1'b0;
        end else if (advance) begin
            out_valid <= 1'b1;
            out_pc <= fetch_pc;
            out_instr <= fault ? NOP : mem[idx];
            out_fault <= fault;
            if (!fault) fetch_pc <= fetch_pc + XLEN'(4);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed-vector self-checking bench for fetch_unit
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_we = 1'b0;
    logic [4:0]  imem_waddr = '0;
    logic [31:0] imem_wdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_fault;

    int tests = 0;
    int fails = 0;

    fetch_unit #(.XLEN(32), .DEPTH(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_fault(out_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write(input logic [4:0] a, input logic [31:0] d);
        imem_we = 1'b1;
        imem_waddr = a;
        imem_wdata = d;
        tick();
        imem_we = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc = pc;
        tick();
        check("redir_bubble", {31'b0, out_valid}, 32'd0);
        redirect_valid = 1'b0;
        tick();
    endtask

    task automatic expect_out(input string tag, input logic [31:0] pc, input logic [31:0] ins, input logic flt);
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_pc"}, out_pc, pc);
        check({tag, "_instr"}, out_instr, ins);
        check({tag, "_fault"}, {31'b0, out_fault}, {31'b0, flt});
    endtask

    localparam logic [31:0] M0 = 32'h005303B3, M1 = 32'h00000013, M2 = 32'h00100093,
                            M3 = 32'h00208113, M4 = 32'h00400213, M31 = 32'h11111111;

    initial begin
        @(negedge clk);
        write(5'd0, M0);
        write(5'd1, M1);
        write(5'd2, M2);
        write(5'd3, M3);
        write(5'd4, M4);
        write(5'd31, M31);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_fault", {31'b0, out_fault}, 32'd0);
        // sequential fetch
        reset = 1'b0;
        tick(); expect_out("seq0", 32'h0, M0, 1'b0);
        tick(); expect_out("seq1", 32'h4, M1, 1'b0);
        tick(); expect_out("seq2", 32'h8, M2, 1'b0);
        tick(); expect_out("seq3", 32'hC, M3, 1'b0);
        // backpressure from a fresh start
        reset = 1'b1;
        out_ready = 1'b0;
        tick();
        reset = 1'b0;
        tick(); expect_out("bp_first", 32'h0, M0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("bp_hold", 32'h0, M0, 1'b0);
        end
        out_ready = 1'b1;
        tick(); expect_out("bp_release", 32'h4, M1, 1'b0);
        // redirect while pc 4 is valid
        redirect(32'h10);
        expect_out("redir_target", 32'h10, M4, 1'b0);
        // range fault
        redirect(32'h7C);
        expect_out("range_last", 32'h7C, M31, 1'b0);
        tick(); expect_out("range_fault", 32'h80, 32'h00000013, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("halt_idle", {31'b0, out_valid}, 32'd0);
        end
        redirect(32'h0);
        expect_out("resume", 32'h0, M0, 1'b0);
        // misaligned redirect
        redirect(32'h6);
        expect_out("misalign", 32'h6, 32'h00000013, 1'b1);
        tick(); check("misalign_consumed", {31'b0, out_valid}, 32'd0);
        tick(); check("misalign_halt", {31'b0, out_valid}, 32'd0);
        // async reset mid-stall
        redirect(32'h0);
        expect_out("pre_rst0", 32'h0, M0, 1'b0);
        tick();
        out_ready = 1'b0;
        tick(); expect_out("pre_rst_stall", 32'h4, M1, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("async_valid", {31'b0, out_valid}, 32'd0);
        check("async_pc", out_pc, 32'd0);
        check("async_instr", out_instr, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        tick(); expect_out("mem_kept", 32'h0, M0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
